// File: rtl/game_round_sequencer_pkg.sv
// Shared game-session types: state encoding seen by the game logic and default coordinate width.
package game_round_sequencer_pkg;

   localparam int COORD_W_DEF = 11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_ROUND_END = 3'd3,
      ST_GAME_OVER = 3'd4
   } game_state_e;

endpackage

// File: rtl/game_round_sequencer_if.sv
// Bundle between predictor/VGA timing (master side) and the round sequencer (slave side).
interface game_round_sequencer_if
   import game_round_sequencer_pkg::*;
#(
   parameter int COORD_W = 11,
   parameter int N_OBJ   = 2,
   parameter int CNT_W   = 16,
   parameter int RND_W   = 2
);
   logic                            start;
   logic                            frame_end;
   logic                            predict_valid;
   logic [N_OBJ-1:0][COORD_W-1:0]   pred_left;
   logic [N_OBJ-1:0][COORD_W-1:0]   pred_right;
   logic [N_OBJ-1:0][COORD_W-1:0]   pred_up;
   logic [N_OBJ-1:0][COORD_W-1:0]   pred_down;
   logic                            round_over;
   logic                            enter_game;
   logic                            game_start;
   logic [N_OBJ-1:0][COORD_W-1:0]   box_left;
   logic [N_OBJ-1:0][COORD_W-1:0]   box_right;
   logic [N_OBJ-1:0][COORD_W-1:0]   box_up;
   logic [N_OBJ-1:0][COORD_W-1:0]   box_down;
   logic                            box_valid;
   game_state_e                     state;
   logic [CNT_W-1:0]                frames_left;
   logic [RND_W-1:0]                round;

   modport master (
      output start, frame_end, predict_valid, pred_left, pred_right, pred_up, pred_down, round_over,
      input  enter_game, game_start, box_left, box_right, box_up, box_down, box_valid, state,
             frames_left, round
   );

   modport slave (
      input  start, frame_end, predict_valid, pred_left, pred_right, pred_up, pred_down, round_over,
      output enter_game, game_start, box_left, box_right, box_up, box_down, box_valid, state,
             frames_left, round
   );
endinterface

// File: rtl/game_round_sequencer_box_double_buffer.sv
// Holds predictor boxes in a shadow register and commits them only at frame end; drops valid when stale.
module game_round_sequencer_box_double_buffer #(
   parameter int BOX_W        = 88,
   parameter int STALE_FRAMES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_end,
   input  logic             predict_valid,
   input  logic [BOX_W-1:0] pred,
   output logic [BOX_W-1:0] box,
   output logic             box_valid
);
   localparam int SW = (STALE_FRAMES < 1) ? 1 : $clog2(STALE_FRAMES + 1);
   localparam logic [SW-1:0] STALE_MAX = SW'(STALE_FRAMES);

   logic [BOX_W-1:0] shadow;
   logic             pending;
   logic [SW-1:0]    stale;
   logic [SW-1:0]    stale_inc;

   always_comb begin
      stale_inc = (stale == STALE_MAX) ? stale : stale + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow    <= '0;
         pending   <= 1'b0;
         stale     <= '0;
         box       <= '0;
         box_valid <= 1'b0;
      end else begin
         if (predict_valid) shadow <= pred;
         if (frame_end) begin
            // a prediction arriving with the frame end bypasses the shadow
            if (predict_valid || pending) begin
               box       <= predict_valid ? pred : shadow;
               pending   <= 1'b0;
               stale     <= '0;
               box_valid <= 1'b1;
            end else begin
               stale <= stale_inc;
               if (stale_inc == STALE_MAX) box_valid <= 1'b0;
            end
         end else if (predict_valid) begin
            pending <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/game_round_sequencer.sv
// Game session FSM (idle, countdown, rounds, game over) with frame counter and box double buffer.
module game_round_sequencer
   import game_round_sequencer_pkg::*;
#(
   parameter int COORD_W          = COORD_W_DEF,
   parameter int N_OBJ            = 2,
   parameter int COUNTDOWN_FRAMES = 180,
   parameter int ROUND_FRAMES     = 1800,
   parameter int RESULT_FRAMES    = 120,
   parameter int N_ROUNDS         = 3,
   parameter int STALE_FRAMES     = 8,
   parameter int CNT_W            = 16,
   parameter int RND_W            = $clog2(N_ROUNDS + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   game_round_sequencer_if.slave  bus
);
   // state        | meaning
   // ST_IDLE      | waiting for start, game screen off
   // ST_COUNTDOWN | pre-round countdown
   // ST_PLAY      | round in progress
   // ST_ROUND_END | showing round result
   // ST_GAME_OVER | all rounds done, waiting for restart
   localparam int BOX_W = 4 * N_OBJ * COORD_W;
   localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COUNTDOWN_FRAMES);
   localparam logic [CNT_W-1:0] RND_LOAD = CNT_W'(ROUND_FRAMES);
   localparam logic [CNT_W-1:0] RES_LOAD = CNT_W'(RESULT_FRAMES);
   localparam logic [RND_W-1:0] LAST_RND = RND_W'(N_ROUNDS - 1);

   game_state_e      state, state_nxt;
   logic [CNT_W-1:0] frames_left, frames_nxt;
   logic [RND_W-1:0] round, round_nxt;
   logic             start_nxt, enter_q, start_q;
   logic             last_frame;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         frames_left <= '0;
         round       <= '0;
         enter_q     <= 1'b0;
         start_q     <= 1'b0;
      end else begin
         state       <= state_nxt;
         frames_left <= frames_nxt;
         round       <= round_nxt;
         start_q     <= start_nxt;
         enter_q     <= (state_nxt == ST_COUNTDOWN) || (state_nxt == ST_PLAY) ||
                        (state_nxt == ST_ROUND_END);
      end
   end

   always_comb begin
      state_nxt  = state;
      frames_nxt = frames_left;
      round_nxt  = round;
      start_nxt  = 1'b0;
      last_frame = bus.frame_end && (frames_left == CNT_W'(1));
      case (state)
         ST_IDLE, ST_GAME_OVER: begin
            if (bus.start) begin
               state_nxt  = ST_COUNTDOWN;
               round_nxt  = '0;
               frames_nxt = CD_LOAD;
            end
         end
         ST_COUNTDOWN: begin
            if (last_frame) begin
               state_nxt  = ST_PLAY;
               frames_nxt = RND_LOAD;
               start_nxt  = 1'b1;
            end else if (bus.frame_end && frames_left != '0) begin
               frames_nxt = frames_left - 1'b1;
            end
         end
         ST_PLAY: begin
            if (bus.round_over || last_frame) begin
               state_nxt  = ST_ROUND_END;
               frames_nxt = RES_LOAD;
            end else if (bus.frame_end && frames_left != '0) begin
               frames_nxt = frames_left - 1'b1;
            end
         end
         ST_ROUND_END: begin
            if (last_frame) begin
               if (round == LAST_RND) begin
                  state_nxt  = ST_GAME_OVER;
                  frames_nxt = '0;
               end else begin
                  state_nxt  = ST_COUNTDOWN;
                  round_nxt  = round + 1'b1;
                  frames_nxt = CD_LOAD;
               end
            end else if (bus.frame_end && frames_left != '0) begin
               frames_nxt = frames_left - 1'b1;
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            frames_nxt = '0;
            round_nxt  = '0;
         end
      endcase
   end

   assign bus.state       = state;
   assign bus.frames_left = frames_left;
   assign bus.round       = round;
   assign bus.enter_game  = enter_q;
   assign bus.game_start  = start_q;

   logic [BOX_W-1:0] pred_all, box_all;
   assign pred_all = {bus.pred_left, bus.pred_right, bus.pred_up, bus.pred_down};
   assign {bus.box_left, bus.box_right, bus.box_up, bus.box_down} = box_all;

   game_round_sequencer_box_double_buffer #(
      .BOX_W        (BOX_W),
      .STALE_FRAMES (STALE_FRAMES)
   ) u_box (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_end     (bus.frame_end),
      .predict_valid (bus.predict_valid),
      .pred          (pred_all),
      .box           (box_all),
      .box_valid     (bus.box_valid)
   );
endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed bench for game_round_sequencer: vector table for a full game plus reset and overlap corner cases.
module tb_game_round_sequencer;
   import game_round_sequencer_pkg::*;

   localparam int COORD_W = 11;
   localparam int N_OBJ   = 2;
   localparam int CNT_W   = 16;
   localparam int N_RND   = 2;
   localparam int RND_W   = $clog2(N_RND + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   game_round_sequencer_if #(.COORD_W(COORD_W), .N_OBJ(N_OBJ), .CNT_W(CNT_W), .RND_W(RND_W)) bus ();

   game_round_sequencer #(
      .COORD_W(COORD_W), .N_OBJ(N_OBJ), .COUNTDOWN_FRAMES(3), .ROUND_FRAMES(4),
      .RESULT_FRAMES(2), .N_ROUNDS(N_RND), .STALE_FRAMES(2), .CNT_W(CNT_W), .RND_W(RND_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      bit st, fe, pv, ro;
      int l0;
      int e_state, e_fl, e_rnd;
      bit e_ent, e_gs;
      int e_bl0;
      bit e_bv;
   } vec_t;

   vec_t vq[$];

   task automatic add(bit st, bit fe, bit pv, bit ro, int l0,
                      int es, int efl, int er, bit eent, bit egs, int ebl0, bit ebv);
      vec_t v;
      v = '{st, fe, pv, ro, l0, es, efl, er, eent, egs, ebl0, ebv};
      vq.push_back(v);
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.start = 1'b0; bus.frame_end = 1'b0; bus.predict_valid = 1'b0; bus.round_over = 1'b0;
   endtask

   task automatic step(bit st, bit fe, bit pv, bit ro, int l0);
      @(negedge clk);
      bus.start = st; bus.frame_end = fe; bus.predict_valid = pv; bus.round_over = ro;
      bus.pred_left[0] = COORD_W'(l0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_core(string tag, int es, int efl, int er);
      chk({tag, ".state"},  int'(bus.state), es);
      chk({tag, ".frames"}, int'(bus.frames_left), efl);
      chk({tag, ".round"},  int'(bus.round), er);
   endtask

   initial begin
      bus.pred_left = '0; bus.pred_right = '0; bus.pred_up = '0; bus.pred_down = '0;
      idle_inputs();

      //  st fe pv ro  l0   state fl rnd ent gs  bl0 bv
      add(0, 0, 0, 0,   0,   0,   0, 0,  0,  0,   0, 0);
      add(0, 0, 1, 0, 100,   0,   0, 0,  0,  0,   0, 0);
      add(0, 0, 0, 0,   0,   0,   0, 0,  0,  0,   0, 0);
      add(1, 0, 0, 0,   0,   1,   3, 0,  1,  0,   0, 0);
      add(0, 1, 0, 0,   0,   1,   2, 0,  1,  0, 100, 1);
      add(0, 1, 0, 0,   0,   1,   1, 0,  1,  0, 100, 1);
      add(0, 1, 1, 0, 200,   2,   4, 0,  1,  1, 200, 1);
      add(0, 0, 0, 0,   0,   2,   4, 0,  1,  0, 200, 1);
      add(0, 1, 0, 0,   0,   2,   3, 0,  1,  0, 200, 1);
      add(0, 1, 0, 0,   0,   2,   2, 0,  1,  0, 200, 0);
      add(0, 1, 0, 0,   0,   2,   1, 0,  1,  0, 200, 0);
      add(0, 1, 0, 0,   0,   3,   2, 0,  1,  0, 200, 0);
      add(1, 0, 0, 0,   0,   3,   2, 0,  1,  0, 200, 0);
      add(0, 1, 0, 0,   0,   3,   1, 0,  1,  0, 200, 0);
      add(0, 1, 0, 0,   0,   1,   3, 1,  1,  0, 200, 0);
      add(0, 0, 0, 1,   0,   1,   3, 1,  1,  0, 200, 0);
      add(0, 1, 0, 0,   0,   1,   2, 1,  1,  0, 200, 0);
      add(0, 1, 0, 0,   0,   1,   1, 1,  1,  0, 200, 0);
      add(0, 1, 0, 0,   0,   2,   4, 1,  1,  1, 200, 0);
      add(0, 1, 0, 0,   0,   2,   3, 1,  1,  0, 200, 0);
      add(0, 0, 0, 1,   0,   3,   2, 1,  1,  0, 200, 0);
      add(0, 1, 0, 1,   0,   3,   1, 1,  1,  0, 200, 0);
      add(0, 1, 0, 0,   0,   4,   0, 1,  0,  0, 200, 0);
      add(0, 1, 0, 0,   0,   4,   0, 1,  0,  0, 200, 0);
      add(1, 0, 0, 0,   0,   1,   3, 0,  1,  0, 200, 0);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         step(vq[i].st, vq[i].fe, vq[i].pv, vq[i].ro, vq[i].l0);
         chk_core(tag, vq[i].e_state, vq[i].e_fl, vq[i].e_rnd);
         chk({tag, ".enter"},  int'(bus.enter_game), int'(vq[i].e_ent));
         chk({tag, ".gstart"}, int'(bus.game_start), int'(vq[i].e_gs));
         chk({tag, ".left0"},  int'(bus.box_left[0]), vq[i].e_bl0);
         chk({tag, ".bvalid"}, int'(bus.box_valid), int'(vq[i].e_bv));
      end

      // countdown to PLAY, then frame end and round_over in the same cycle
      repeat (3) step(0, 1, 0, 0, 0);
      chk_core("h_play", 2, 4, 0);
      chk("h_play.gstart", int'(bus.game_start), 1);
      step(0, 1, 0, 1, 0);
      chk_core("h_overlap", 3, 2, 0);
      chk("h_overlap.gstart", int'(bus.game_start), 0);
      repeat (2) step(0, 1, 0, 0, 0);
      chk_core("h_round1", 1, 3, 1);
      repeat (3) step(0, 1, 0, 0, 0);
      chk_core("h_play1", 2, 4, 1);
      step(0, 1, 1, 0, 300);
      chk_core("h_pre_rst", 2, 3, 1);
      chk("h_pre_rst.left0", int'(bus.box_left[0]), 300);
      chk("h_pre_rst.bvalid", int'(bus.box_valid), 1);

      // asynchronous reset mid-PLAY, sampled before any clock edge
      @(negedge clk);
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      chk_core("h_rst", 0, 0, 0);
      chk("h_rst.enter", int'(bus.enter_game), 0);
      chk("h_rst.gstart", int'(bus.game_start), 0);
      chk("h_rst.left0", int'(bus.box_left[0]), 0);
      chk("h_rst.bvalid", int'(bus.box_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1, 0, 0, 0);
      chk_core("h_idle_fe", 0, 0, 0);
      chk("h_idle_fe.bvalid", int'(bus.box_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
